// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation adder operand-B sequencer.
// Schedule length depends on INTERP_ROUND_EN (prepends a rounding step per pass).
package interp_pkg;

   localparam logic [2:0] SEL_RND  = 3'b000;
   localparam logic [2:0] SEL_2E3  = 3'b001;
   localparam logic [2:0] SEL_5E   = 3'b010;
   localparam logic [2:0] SEL_2E4  = 3'b011;
   localparam logic [2:0] SEL_N2E  = 3'b100;
   localparam logic [2:0] SEL_E1   = 3'b110;
   localparam logic [2:0] SEL_ZERO = 3'b111;

`ifdef INTERP_ROUND_EN
   localparam int SCHED_LEN = 6;
`else
   localparam int SCHED_LEN = 5;
`endif

   localparam int STEP_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic [2:0] sel_b;
      logic       ld_2e;
      logic       ld_5e;
      logic       out_vld;
      logic [1:0] out_idx;
   } step_rec_t;

   localparam step_rec_t REC_IDLE = '{SEL_ZERO, 1'b0, 1'b0, 1'b0, 2'd0};

endpackage

// File: rtl/interp_sched_rom.sv
// Combinational step-to-record lookup of the per-pass operand-B schedule.
// The INTERP_ROUND_EN variant adds a leading SEL_RND step.
module interp_sched_rom
   import interp_pkg::*;
(
   input  logic [STEP_W-1:0] step_i,
   output step_rec_t         rec_o
);

   localparam step_rec_t SCHED [SCHED_LEN] = '{
`ifdef INTERP_ROUND_EN
      '{SEL_RND, 1'b0, 1'b0, 1'b0, 2'd0},
`endif
      '{SEL_2E3, 1'b1, 1'b0, 1'b0, 2'd0},
      '{SEL_2E4, 1'b0, 1'b1, 1'b0, 2'd0},
      '{SEL_5E,  1'b0, 1'b0, 1'b1, 2'd0},
      '{SEL_E1,  1'b0, 1'b0, 1'b1, 2'd1},
      '{SEL_N2E, 1'b0, 1'b0, 1'b1, 2'd2}
   };

   // Table lookup; unused counter values fall back to the zero-operand record
   always_comb begin
      if (step_i < STEP_W'(SCHED_LEN)) begin
         rec_o = SCHED[step_i];
      end else begin
         rec_o = REC_IDLE;
      end
   end

endmodule

// File: rtl/interp_add1_seq.sv
// Operand-B select sequencer for the channel-estimation interpolation adder.
// Build option: INTERP_ROUND_EN (see interp_pkg / interp_sched_rom).
module interp_add1_seq
   import interp_pkg::*;
#(
   parameter  int NUM_PASS = 2,
   parameter  int IDX_W    = 4,
   localparam int PASS_W   = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   input  logic              out_ready,
   output logic [2:0]        sel_b,
   output logic              ld_2e,
   output logic              ld_5e,
   output logic              add_en,
   output logic              out_valid,
   output logic [IDX_W-1:0]  out_idx,
   output logic [PASS_W-1:0] pass_idx,
   output logic              busy,
   output logic              done
);

   typedef struct packed {
      logic [2:0]       sel_b;
      logic             ld_2e;
      logic             ld_5e;
      logic             add_en;
      logic             out_valid;
      logic [IDX_W-1:0] out_idx;
      logic             busy;
      logic             done;
   } out_t;

   function automatic out_t idle_outs(input logic done_v);
      out_t o;
      o.sel_b     = SEL_ZERO;
      o.ld_2e     = 1'b0;
      o.ld_5e     = 1'b0;
      o.add_en    = 1'b0;
      o.out_valid = 1'b0;
      o.out_idx   = IDX_W'(0);
      o.busy      = 1'b0;
      o.done      = done_v;
      return o;
   endfunction

   function automatic out_t step_outs(input step_rec_t r);
      out_t o;
      o.sel_b     = r.sel_b;
      o.ld_2e     = r.ld_2e;
      o.ld_5e     = r.ld_5e;
      o.add_en    = 1'b1;
      o.out_valid = r.out_vld;
      o.out_idx   = IDX_W'(r.out_idx);
      o.busy      = 1'b1;
      o.done      = 1'b0;
      return o;
   endfunction

   state_e            state_q;
   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] step_d;
   logic [PASS_W-1:0] pass_q;
   logic [PASS_W-1:0] pass_d;
   logic [STEP_W-1:0] rom_idx_s;
   logic              last_step_s;
   logic              last_pass_s;
   logic              adv_s;
   step_rec_t         rec_s;
   out_t              out_q;

   interp_sched_rom u_rom (
      .step_i (rom_idx_s),
      .rec_o  (rec_s)
   );

   // Next step/pass candidates and the advance condition for RUN/HOLD
   always_comb begin
      last_step_s = (step_q == STEP_W'(SCHED_LEN - 1));
      last_pass_s = (pass_q == PASS_W'(NUM_PASS - 1));
      if (last_step_s) begin
         step_d = STEP_W'(0);
         pass_d = pass_q + PASS_W'(1);
      end else begin
         step_d = step_q + STEP_W'(1);
         pass_d = pass_q;
      end
      if (state_q == IDLE) begin
         rom_idx_s = STEP_W'(0);
      end else begin
         rom_idx_s = step_d;
      end
      if (state_q == RUN) begin
         adv_s = !(out_q.out_valid && !out_ready);
      end else if (state_q == HOLD) begin
         adv_s = out_ready;
      end else begin
         adv_s = 1'b0;
      end
   end

   // Sequencer FSM with registered outputs; flush behaves exactly like reset
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q <= IDLE;
         step_q  <= STEP_W'(0);
         pass_q  <= PASS_W'(0);
         out_q   <= idle_outs(1'b0);
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  step_q  <= STEP_W'(0);
                  pass_q  <= PASS_W'(0);
                  out_q   <= step_outs(rec_s);
               end else begin
                  state_q <= IDLE;
                  out_q   <= idle_outs(1'b0);
               end
            end
            RUN, HOLD: begin
               if (adv_s) begin
                  if (last_step_s && last_pass_s) begin
                     state_q <= DONE;
                     step_q  <= STEP_W'(0);
                     pass_q  <= PASS_W'(0);
                     out_q   <= idle_outs(1'b1);
                  end else begin
                     state_q <= RUN;
                     step_q  <= step_d;
                     pass_q  <= pass_d;
                     out_q   <= step_outs(rec_s);
                  end
               end else begin
                  // Sample presented but not accepted: freeze it, drop the strobes
                  state_q      <= HOLD;
                  out_q.add_en <= 1'b0;
                  out_q.ld_2e  <= 1'b0;
                  out_q.ld_5e  <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               step_q  <= STEP_W'(0);
               pass_q  <= PASS_W'(0);
               out_q   <= idle_outs(1'b0);
            end
            default: begin
               state_q <= IDLE;
               step_q  <= STEP_W'(0);
               pass_q  <= PASS_W'(0);
               out_q   <= idle_outs(1'b0);
            end
         endcase
      end
   end

   assign sel_b     = out_q.sel_b;
   assign ld_2e     = out_q.ld_2e;
   assign ld_5e     = out_q.ld_5e;
   assign add_en    = out_q.add_en;
   assign out_valid = out_q.out_valid;
   assign out_idx   = out_q.out_idx;
   assign busy      = out_q.busy;
   assign done      = out_q.done;
   assign pass_idx  = pass_q;

endmodule
